mux_scan_ctrl: RTL and testbench
================================

Name: mux_scan_ctrl

Overview:
Sequencer that sits directly upstream of mux41. It drives mux41's 2-bit select, waits a programmable settle time on each channel, and samples mux41's Y output. After one scan of all four inputs (D1..D4) it presents a 4-bit snapshot. A start/busy/done handshake lets a controller trigger single scans.

Parameters:
DWELL, 4, clock cycles S is held per channel before Y is sampled (legal 1..255).
CNT_W, 8, width of the dwell counter (must hold DWELL-1).

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
start  input  1  scan request, sampled in IDLE only
S  output  2  select to mux41 (00=D1, 01=D2, 10=D3, 11=D4)
Y_in  input  1  mux41 Y output
busy  output  1  high from the cycle after start is accepted until DONE exits
done  output  1  one-cycle pulse when sample is updated
sample  output  4  scan result; bit0=D1, bit1=D2, bit2=D3, bit3=D4
sample_valid  output  1  high once any scan has completed since reset

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE, S=2'b00, counter=0, busy=0, done=0, sample=4'h0, sample_valid=0. Reset overrides everything, including a scan in progress; the partial scan is discarded.
- States: IDLE, DWELL, LAST, DONE.
- IDLE:
  - S=00, busy=0.
  - start=1 -> DWELL with channel=0 and counter=DWELL-1.
- DWELL:
  - S=channel, busy=1. Counter decrements each cycle.
  - When counter==0 (or immediately if DWELL=1), the state at that edge captures Y_in into shadow[channel].
  - If channel<3: channel+1, counter reloads DWELL-1, stay in DWELL.
  - If channel==3: -> DONE.
- LAST: reserved, unused encoding; falls to IDLE.
- DONE (one cycle):
  - sample<=shadow, done=1, sample_valid<=1, busy=1 in this cycle.
  - -> IDLE; S returns to 00.
- Latency: start accepted at edge N. Y for channel k is sampled at edge N+(k+1)*DWELL. done is high in the cycle after edge N+4*DWELL. Total is 4*DWELL+1 cycles from start to done.
- Capture order:
  - sample changes only in DONE, never mid-scan.
  - shadow is internal.
  - sample holds its value between scans.
- start while busy: ignored, not queued.
- start held high continuously: a new scan begins in the IDLE cycle after DONE (one idle cycle between scans).
- Y_in is assumed stable after one cycle of the select change. With DWELL>=1 the sample is taken at least one full cycle after S changes.
- Reset mid-scan: S=00 and busy=0 on the next cycle; sample keeps no partial data (cleared to 0).

Optional Feature:
MUX_SCAN_CONT_EN
- Defined: continuous mode. After DONE the FSM goes directly to DWELL with channel=0 without an IDLE cycle. busy stays 1 and done pulses every 4*DWELL+1 cycles. start is still required to leave IDLE after reset. A new input cont_stop (1 bit) returns the FSM to IDLE at the next DONE.
- Not defined: single-shot behaviour as above; cont_stop port absent.

Test Plan:
- Reset check: hold rst 2 cycles -> S=00, busy=0, done=0, sample=0000, sample_valid=0.
- Basic scan, DWELL=4, D1..D4=0,1,0,1: pulse start -> S steps 00,01,10,11 each for 4 cycles. done pulses exactly 17 cycles after start, sample=4'b1010, sample_valid=1.
- Busy ignore: pulse start again 5 cycles into the scan -> no restart, done count=1, timing unchanged.
- Reset mid-scan: assert rst while S=10 -> next cycle S=00, busy=0, sample=0000, no done pulse.
- DWELL=1 boundary: D1..D4=1,1,0,0 -> S changes every cycle, done 5 cycles after start, sample=4'b0011.
- Back-to-back (start tied high), data changed to all 1s between scans: first sample=1010, second sample=1111, one IDLE cycle between them. With MUX_SCAN_CONT_EN: no IDLE gap, and cont_stop halts the scans after the current one.

Source files
------------

// File: rtl/mux_scan_ctrl.sv
// rtl/mux_scan_ctrl.sv - four-channel scan sequencer driving mux41's select and sampling its Y output
//
// Steps S through D1..D4, holds each select for DWELL cycles, captures Y_in
// on the last dwell cycle of each channel and publishes all four bits as one
// snapshot when the scan completes.
//
// Optional feature macro: MUX_SCAN_CONT_EN (continuous back-to-back scans,
// adds the cont_stop input).
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   start        scan request, honoured only while idle
//   cont_stop    (MUX_SCAN_CONT_EN only) end continuous scanning at next DONE
//   S            mux41 select (00=D1 .. 11=D4)
//   Y_in         mux41 Y output
//   busy         high while a scan is running, including the DONE cycle
//   done         one-cycle pulse while the new sample is first presented
//   sample       last completed scan, bit0=D1 .. bit3=D4
//   sample_valid high once any scan has completed since reset
module mux_scan_ctrl #(
    parameter int DWELL = 4,
    parameter int CNT_W = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
`ifdef MUX_SCAN_CONT_EN
    input  logic       cont_stop,
`endif
    output logic [1:0] S,
    input  logic       Y_in,
    output logic       busy,
    output logic       done,
    output logic [3:0] sample,
    output logic       sample_valid
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_DWELL = 2'b01,
        ST_LAST  = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(DWELL - 1);

    state_t           state_q, state_d;
    logic [1:0]       chan_q, chan_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    // Only D1..D3 need holding; D4 is captured on the same edge that
    // loads the published sample.
    logic [2:0]       shadow_q, shadow_d;
    logic [3:0]       sample_q, sample_d;
    logic             valid_q, valid_d;
`ifdef MUX_SCAN_CONT_EN
    // Remembers a cont_stop seen anywhere during the current scan.
    logic             stop_q, stop_d;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            chan_q   <= 2'b00;
            cnt_q    <= '0;
            shadow_q <= 3'b000;
            sample_q <= 4'h0;
            valid_q  <= 1'b0;
`ifdef MUX_SCAN_CONT_EN
            stop_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            chan_q   <= chan_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            sample_q <= sample_d;
            valid_q  <= valid_d;
`ifdef MUX_SCAN_CONT_EN
            stop_q   <= stop_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        chan_d   = chan_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        sample_d = sample_q;
        valid_d  = valid_q;
        S        = 2'b00;
        busy     = 1'b0;
        done     = 1'b0;
`ifdef MUX_SCAN_CONT_EN
        stop_d   = (state_q == ST_IDLE) ? 1'b0 : (stop_q | cont_stop);
`endif

        case (state_q)
            ST_IDLE: begin
                chan_d = 2'b00;
                cnt_d  = '0;
                if (start) begin
                    state_d = ST_DWELL;
                    cnt_d   = RELOAD;
                end
            end

            ST_DWELL: begin
                S    = chan_q;
                busy = 1'b1;
                if (cnt_q == '0) begin
                    if (chan_q == 2'd3) begin
                        // Publish on entry to DONE so sample is already
                        // new while done is high.
                        state_d  = ST_DONE;
                        sample_d = {Y_in, shadow_q};
                        valid_d  = 1'b1;
                        cnt_d    = '0;
                    end else begin
                        case (chan_q)
                            2'd0:    shadow_d[0] = Y_in;
                            2'd1:    shadow_d[1] = Y_in;
                            default: shadow_d[2] = Y_in;
                        endcase
                        chan_d = chan_q + 2'd1;
                        cnt_d  = RELOAD;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            ST_DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = ST_IDLE;
                chan_d  = 2'b00;
`ifdef MUX_SCAN_CONT_EN
                if (!(stop_q || cont_stop)) begin
                    state_d = ST_DWELL;
                    cnt_d   = RELOAD;
                end
`endif
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign sample       = sample_q;
    assign sample_valid = valid_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// tb/tb_mux_scan_ctrl.sv - scoreboard bench for mux_scan_ctrl (DWELL=4 and DWELL=1 instances)
module tb_mux_scan_ctrl;

    typedef struct {
        logic [3:0] smp;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start4 = 1'b0, start1 = 1'b0;
    logic       cs4 = 1'b1, cs1 = 1'b1;
    logic [3:0] d4 = 4'h0, d1 = 4'h0;
    logic [1:0] s4, s1;
    logic       y4, y1;
    logic       busy4, busy1, done4, done1, valid4, valid1;
    logic [3:0] sample4, sample1;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   n_done4 = 0;
    int   n_done1 = 0;
    int   e_cyc;
    int   n_save;
    exp_t q4[$];
    exp_t q1[$];
    exp_t e4, e1;

    assign y4 = d4[s4];
    assign y1 = d1[s1];

    mux_scan_ctrl #(.DWELL(4), .CNT_W(8)) u_dut4 (
        .clk(clk), .rst(rst), .start(start4),
`ifdef MUX_SCAN_CONT_EN
        .cont_stop(cs4),
`endif
        .S(s4), .Y_in(y4), .busy(busy4), .done(done4),
        .sample(sample4), .sample_valid(valid4)
    );

    mux_scan_ctrl #(.DWELL(1), .CNT_W(8)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1),
`ifdef MUX_SCAN_CONT_EN
        .cont_stop(cs1),
`endif
        .S(s1), .Y_in(y1), .busy(busy1), .done(done1),
        .sample(sample1), .sample_valid(valid1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitors: pop the scoreboard whenever a DUT pulses done.
    always @(negedge clk) begin
        if (done4 === 1'b1) begin
            n_done4++;
            if (q4.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL done4_unexpected actual=cycle %0d required=no done", cyc);
            end else begin
                e4 = q4.pop_front();
                check("done4_sample", 32'(sample4), 32'(e4.smp));
                check("done4_valid", 32'(valid4), 32'd1);
                check("done4_cycle", 32'(cyc), 32'(e4.cyc));
            end
        end
    end

    always @(negedge clk) begin
        if (done1 === 1'b1) begin
            n_done1++;
            if (q1.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL done1_unexpected actual=cycle %0d required=no done", cyc);
            end else begin
                e1 = q1.pop_front();
                check("done1_sample", 32'(sample1), 32'(e1.smp));
                check("done1_valid", 32'(valid1), 32'd1);
                check("done1_cycle", 32'(cyc), 32'(e1.cyc));
            end
        end
    end

    initial begin
        // Reset held for two edges
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_S", 32'(s4), 32'd0);
        check("rst_busy", 32'(busy4), 32'd0);
        check("rst_done", 32'(done4), 32'd0);
        check("rst_sample", 32'(sample4), 32'd0);
        check("rst_valid", 32'(valid4), 32'd0);
        check("rst_valid1", 32'(valid1), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Basic scan DWELL=4, D1..D4 = 0,1,0,1; second start at cycle 5 ignored
        d4 = 4'b1010;
        start4 = 1'b1;
        e_cyc = cyc + 1;
        q4.push_back('{smp: 4'b1010, cyc: e_cyc + 16});
        for (int j = 0; j < 16; j++) begin
            @(negedge clk);
            check("basic_S", 32'(s4), 32'(j / 4));
            check("basic_busy", 32'(busy4), 32'd1);
            start4 = (j == 5);
        end
        start4 = 1'b0;
        repeat (4) @(negedge clk);
        check("basic_done_count", 32'(n_done4), 32'd1);
        check("basic_idle_busy", 32'(busy4), 32'd0);
        check("basic_hold_sample", 32'(sample4), 32'b1010);

        // Reset while S=10
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        repeat (8) @(negedge clk);
        check("midrst_S_before", 32'(s4), 32'd2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_S", 32'(s4), 32'd0);
        check("midrst_busy", 32'(busy4), 32'd0);
        check("midrst_sample", 32'(sample4), 32'd0);
        check("midrst_valid", 32'(valid4), 32'd0);
        n_save = n_done4;
        repeat (20) @(negedge clk);
        check("midrst_no_done", 32'(n_done4), 32'(n_save));

        // DWELL=1 boundary, D1..D4 = 1,1,0,0
        d1 = 4'b0011;
        start1 = 1'b1;
        e_cyc = cyc + 1;
        q1.push_back('{smp: 4'b0011, cyc: e_cyc + 4});
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            start1 = 1'b0;
            check("dw1_S", 32'(s1), 32'(j));
        end
        repeat (4) @(negedge clk);
        check("dw1_done_count", 32'(n_done1), 32'd1);

        // Back-to-back with start held high; data goes to all ones between scans
        d4 = 4'b1010;
`ifdef MUX_SCAN_CONT_EN
        cs4 = 1'b0;
`endif
        start4 = 1'b1;
        e_cyc = cyc + 1;
        q4.push_back('{smp: 4'b1010, cyc: e_cyc + 16});
`ifdef MUX_SCAN_CONT_EN
        q4.push_back('{smp: 4'b1111, cyc: e_cyc + 33});
`else
        q4.push_back('{smp: 4'b1111, cyc: e_cyc + 34});
`endif
        repeat (17) @(negedge clk);
        d4 = 4'hF;
        @(negedge clk);
`ifdef MUX_SCAN_CONT_EN
        check("b2b_gap_busy", 32'(busy4), 32'd1);
`else
        check("b2b_gap_busy", 32'(busy4), 32'd0);
`endif
        @(negedge clk);
        start4 = 1'b0;
        cs4 = 1'b1;
        repeat (40) @(negedge clk);
        check("b2b_idle_busy", 32'(busy4), 32'd0);
        check("total_done4", 32'(n_done4), 32'd3);
        check("q4_drained", 32'(q4.size()), 32'd0);
        check("q1_drained", 32'(q1.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
